// File: rtl/shift_left_sched.sv
// Purpose: round-robin scheduler that shares one shift_left barrel shifter among R valid/ready requesters.
// Latency: 1 cycle from request accept to out_valid; sustains 1 result/cycle while out_ready stays high.
// Backpressure: while out_valid & ~out_ready every req_ready is 0 and out_c/out_id hold.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   req_valid/req_ready per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b        operand of requester i at [i*N +: N], shift amount at [i*S +: S]
//   out_valid/out_ready result handshake; out_c = shifted result, out_id = winner index
//   busy                out_valid | (|req_valid)
//   out_ovf             only when SHIFT_OVF_EN is defined: a set bit of a was shifted out
//
// Optional feature macro: SHIFT_OVF_EN (adds out_ovf and the overflow detect logic).

module shift_left #(
    parameter int N = 16,
    parameter int S = 4
) (
    input  logic [N-1:0] a,
    input  logic [S-1:0] b,
`ifdef SHIFT_OVF_EN
    output logic         ovf,
`endif
    output logic [N-1:0] c
);
    assign c = (32'(b) >= N) ? '0 : (a << b);

`ifdef SHIFT_OVF_EN
    // Bits at positions >= N-b leave the word. The all-ones mask shifted right by b
    // keeps the surviving bits; for b >= N it collapses to 0, so any set bit overflows.
    assign ovf = |(a & ~({N{1'b1}} >> b));
`endif
endmodule

module shift_left_sched #(
    parameter int N   = 16,
    parameter int S   = 4,
    parameter int R   = 2,
    localparam int IDW = $clog2(R)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [R*N-1:0] req_a,
    input  logic [R*S-1:0] req_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_c,
    output logic [IDW-1:0] out_id,
`ifdef SHIFT_OVF_EN
    output logic           out_ovf,
`endif
    output logic           busy
);
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           found;
    logic           can_load;
    logic           grant;
    logic [N-1:0]   sh_a;
    logic [S-1:0]   sh_b;
    logic [N-1:0]   sh_c;
`ifdef SHIFT_OVF_EN
    logic           sh_ovf;
`endif

    assign can_load = ~out_valid | out_ready;

    // Scan from rr_ptr, wrapping modulo R; the first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < R; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % R);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // rst_n gating keeps req_ready low while reset is held.
    assign grant = found & can_load & rst_n;

    // Shifter operands come from the winner only; zero when nothing is granted.
    always_comb begin
        req_ready = '0;
        sh_a      = '0;
        sh_b      = '0;
        for (int i = 0; i < R; i++) begin
            if (grant && (win == IDW'(i))) begin
                req_ready[i] = 1'b1;
                sh_a         = req_a[i*N +: N];
                sh_b         = req_b[i*S +: S];
            end
        end
    end

    shift_left #(.N(N), .S(S)) u_shift (
        .a   (sh_a),
        .b   (sh_b),
`ifdef SHIFT_OVF_EN
        .ovf (sh_ovf),
`endif
        .c   (sh_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_c     <= '0;
            out_id    <= '0;
            rr_ptr    <= '0;
`ifdef SHIFT_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else if (grant) begin
            out_valid <= 1'b1;
            out_c     <= sh_c;
            out_id    <= win;
            rr_ptr    <= IDW'((int'(win) + 1) % R);
`ifdef SHIFT_OVF_EN
            out_ovf   <= sh_ovf;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy = out_valid | (|req_valid);
endmodule

// File: tb/tb_shift_left_sched.sv
// Bench for shift_left_sched (N=16, S=4, R=2): directed scenarios followed by random
// traffic, all compared against a behavioural model of the scheduler and shifter.
// Uses out_ovf only when SHIFT_OVF_EN is defined.

module tb_shift_left_sched;
    localparam int N = 16;
    localparam int S = 4;
    localparam int R = 2;

    logic           clk;
    logic           rst_n;
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_a;
    logic [R*S-1:0] req_b;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_c;
    logic [0:0]     out_id;
    logic           busy;
`ifdef SHIFT_OVF_EN
    logic           out_ovf;
`endif

    logic [N-1:0] a_arr [R];
    logic [S-1:0] b_arr [R];
    assign req_a = {a_arr[1], a_arr[0]};
    assign req_b = {b_arr[1], b_arr[0]};

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_ov;
    logic [N-1:0] m_c;
    int          m_id;
    int          m_ptr;
    bit          m_ovf;

    shift_left_sched #(.N(N), .S(S), .R(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_id    (out_id),
`ifdef SHIFT_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift computed in a wide word: the low N bits are the result, anything above is lost.
    function automatic logic [63:0] wide_shift(input logic [N-1:0] a, input logic [S-1:0] b);
        logic [63:0] w;
        w = {48'b0, a};
        return w << b;
    endfunction

    function automatic void model_reset();
        m_ov  = 0;
        m_c   = '0;
        m_id  = 0;
        m_ptr = 0;
        m_ovf = 0;
    endfunction

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle(input string tag);
        int best;
        int bestd;
        bit can_load;
        logic [R-1:0] exp_rdy;
        logic [63:0] w;
        #1;
        can_load = !m_ov || out_ready;
        best  = -1;
        bestd = R;
        for (int i = 0; i < R; i++) begin
            if (req_valid[i] && ((i - m_ptr + R) % R) < bestd) begin
                bestd = (i - m_ptr + R) % R;
                best  = i;
            end
        end
        exp_rdy = '0;
        if (can_load && best >= 0) exp_rdy[best] = 1'b1;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'(exp_rdy));
        chk({tag, "_busy"}, 32'(busy), 32'(m_ov || (req_valid != 0)));
        @(posedge clk);
        if (exp_rdy != 0) begin
            w     = wide_shift(a_arr[best], b_arr[best]);
            m_ov  = 1;
            m_c   = w[N-1:0];
            m_ovf = (w[63:N] != 0);
            m_id  = best;
            m_ptr = (best + 1) % R;
        end else if (out_ready) begin
            m_ov = 0;
        end
        #1;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, "_out_c"}, 32'(out_c), 32'(m_c));
        chk({tag, "_out_id"}, 32'(out_id), 32'(m_id));
`ifdef SHIFT_OVF_EN
        chk({tag, "_out_ovf"}, 32'(out_ovf), 32'(m_ovf));
`endif
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        out_ready = 1'b1;
        a_arr[0]  = 16'h1234; a_arr[1] = 16'hABCD;
        b_arr[0]  = 4'd1;     b_arr[1] = 4'd2;
        model_reset();

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_c", 32'(out_c), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef SHIFT_OVF_EN
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single request, 1 << 3
        req_valid = 2'b01; a_arr[0] = 16'h0001; b_arr[0] = 4'd3;
        cycle("t1");
        chk("t1_c_const", 32'(out_c), 32'h0008);
        chk("t1_id_const", 32'(out_id), 32'd0);

        // Grant to 1 alone so the pointer wraps back to 0.
        req_valid = 2'b10; a_arr[1] = 16'h00F0; b_arr[1] = 4'd4;
        cycle("t1b");

        // 2: both valid for 6 cycles alternate 0,1,...
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            a_arr[0] = 16'($urandom); a_arr[1] = 16'($urandom);
            b_arr[0] = 4'($urandom);  b_arr[1] = 4'($urandom);
            cycle("t2");
            chk("t2_id_seq", 32'(out_id), 32'(k % 2));
            chk("t2_valid", 32'(out_valid), 32'd1);
        end

        // 3: stall with both valid, then release
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_arr[0] = 16'($urandom); a_arr[1] = 16'($urandom);
            cycle("t3_stall");
        end
        chk("t3_rdy_stalled", 32'(req_ready), 32'd0);
        out_ready = 1'b1;
        cycle("t3_release");

        // 4: shift boundaries
        req_valid = 2'b01; a_arr[0] = 16'hFFFF; b_arr[0] = 4'd15;
        cycle("t4a");
        chk("t4a_c_const", 32'(out_c), 32'h8000);
`ifdef SHIFT_OVF_EN
        chk("t4a_ovf_const", 32'(out_ovf), 32'd1);
`endif
        req_valid = 2'b01; a_arr[0] = 16'h0001; b_arr[0] = 4'd15;
        cycle("t4b");
        chk("t4b_c_const", 32'(out_c), 32'h8000);
`ifdef SHIFT_OVF_EN
        chk("t4b_ovf_const", 32'(out_ovf), 32'd0);
`endif
        req_valid = 2'b01; a_arr[0] = 16'hBEEF; b_arr[0] = 4'd0;
        cycle("t4c");
        chk("t4c_c_const", 32'(out_c), 32'hBEEF);

        // 5: async reset with out_valid=1 and pointer at 1
        req_valid = 2'b01; a_arr[0] = 16'h0003; b_arr[0] = 4'd2;
        cycle("t5_pre");
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(out_valid), 32'd0);
        chk("t5_async_c", 32'(out_c), 32'd0);
        chk("t5_async_rdy", 32'(req_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle("t5_post");
        chk("t5_first_grant", 32'(out_id), 32'd0);

        // 6: three transfers from 1 only, then both valid -> 0 then 1
        req_valid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            a_arr[1] = 16'($urandom); b_arr[1] = 4'($urandom);
            cycle("t6_only1");
        end
        req_valid = 2'b11;
        cycle("t6_both_a");
        chk("t6_next0", 32'(out_id), 32'd0);
        cycle("t6_both_b");
        chk("t6_next1", 32'(out_id), 32'd1);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            req_valid = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < R; i++) begin
                a_arr[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                b_arr[i] = 4'($urandom);
            end
            cycle("rnd");
        end

        req_valid = 2'b00;
        out_ready = 1'b1;
        cycle("drain");
        chk("drain_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
